// File: rtl/calc2_req_issuer.sv
// calc2_req_issuer
//   Accepts two-operand operations from upstream and issues each to one calc2
//   request port as a two-cycle sequence (command + operand 1, then operand 2),
//   tagging each with one of four tags. It tracks outstanding tags, matches
//   calc2 responses back to them and emits one completion per operation. A tag
//   left outstanding for TIMEOUT_CYCLES cycles produces a timeout completion.
//
// Ports
//   c_clk, reset                 clock, synchronous active-high reset
//   op_valid/op_ready            upstream handshake
//   op_cmd, op_data1, op_data2   operation to issue
//   req_cmd_out/_data_out/_tag_out   registered calc2 request lane
//   resp_in/resp_data_in/resp_tag_in calc2 response lane
//   cpl_valid/_resp/_data/_tag/_cmd  registered one-cycle completion
//   outstanding                  popcount of busy tags (0..4)
//   err_unexpected               sticky: response seen for a tag not in flight
module calc2_req_issuer #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_data1,
  input  logic [31:0] op_data2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  input  logic [1:0]  resp_tag_in,
  output logic        cpl_valid,
  output logic [1:0]  cpl_resp,
  output logic [31:0] cpl_data,
  output logic [1:0]  cpl_tag,
  output logic [3:0]  cpl_cmd,
  output logic [2:0]  outstanding,
  output logic        err_unexpected
);

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, CMD, OP2} state_t;

  state_t      state_q, state_d;
  logic        accept;

  // Request lane registers
  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic [1:0]  req_tag_q, req_tag_d;
  logic        op_ready_q, op_ready_d;

  // Latched operand 2 and tag of the operation currently being issued
  logic [31:0] data2_q, data2_d;
  logic [1:0]  cur_tag_q, cur_tag_d;

  // Tag tracking
  logic [3:0]  busy_q, busy_d;
  logic [7:0]  cnt_q [4];
  logic [7:0]  cnt_d [4];
  logic [3:0]  cmd_store_q [4];
  logic [3:0]  cmd_store_d [4];
  logic [1:0]  alloc_tag;
  logic [3:0]  alloc_mask;
  logic [3:0]  free_mask;
  logic [3:0]  to_vec;
  logic [1:0]  to_tag;
  logic        resp_hit;
  logic        resp_unexp;

  // Completion registers
  logic        cpl_valid_q, cpl_valid_d;
  logic [1:0]  cpl_resp_q, cpl_resp_d;
  logic [31:0] cpl_data_q, cpl_data_d;
  logic [1:0]  cpl_tag_q, cpl_tag_d;
  logic [3:0]  cpl_cmd_q, cpl_cmd_d;
  logic        err_q, err_d;

  // op_ready is registered, so it already encodes "IDLE or OP2 with a free tag"
  assign accept = op_valid & op_ready_q;

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge c_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? CMD : IDLE;
      CMD:     state_d = OP2;
      OP2:     state_d = accept ? CMD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM outputs
  // Request registers are loaded with what the next state must present, so
  // the CMD beat appears in the cycle right after the accept edge.
  always_comb begin
    req_cmd_d  = 4'd0;
    req_data_d = 32'd0;
    req_tag_d  = 2'd0;
    data2_d    = data2_q;
    cur_tag_d  = cur_tag_q;
    if (accept) begin
      req_cmd_d  = op_cmd;
      req_data_d = op_data1;
      req_tag_d  = alloc_tag;
      data2_d    = op_data2;
      cur_tag_d  = alloc_tag;
    end else if (state_q == CMD) begin
      req_data_d = data2_q;
      req_tag_d  = cur_tag_q;
    end
    // Ready is computed against the next-cycle bitmap: a tag freed this cycle
    // becomes usable from the next cycle on, never in the same one.
    op_ready_d = ((state_d == IDLE) || (state_d == OP2)) && !(&busy_d);
  end

  // ---------------------------------------------------------------- tag tracking and completion
  always_comb begin
    // Lowest-numbered free tag
    alloc_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = 2'(i);
    end
    alloc_mask = accept ? (4'b0001 << alloc_tag) : 4'b0000;

    // Lowest-numbered tag whose counter has saturated
    for (int i = 0; i < 4; i++) begin
      to_vec[i] = busy_q[i] && (cnt_q[i] == TO_VAL);
    end
    to_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (to_vec[i]) to_tag = 2'(i);
    end

    resp_hit   = (resp_in != 2'd0) &&  busy_q[resp_tag_in];
    resp_unexp = (resp_in != 2'd0) && !busy_q[resp_tag_in];

    free_mask   = 4'b0000;
    cpl_valid_d = 1'b0;
    cpl_resp_d  = cpl_resp_q;
    cpl_data_d  = cpl_data_q;
    cpl_tag_d   = cpl_tag_q;
    cpl_cmd_d   = cpl_cmd_q;
    err_d       = err_q | resp_unexp;

    // A matched response wins; any saturated tag waits for a free cycle.
    if (resp_hit) begin
      cpl_valid_d = 1'b1;
      cpl_resp_d  = resp_in;
      cpl_data_d  = resp_data_in;
      cpl_tag_d   = resp_tag_in;
      cpl_cmd_d   = cmd_store_q[resp_tag_in];
      free_mask   = 4'b0001 << resp_tag_in;
    end else if (|to_vec) begin
      cpl_valid_d = 1'b1;
      cpl_resp_d  = 2'd3;
      cpl_data_d  = 32'd0;
      cpl_tag_d   = to_tag;
      cpl_cmd_d   = cmd_store_q[to_tag];
      free_mask   = 4'b0001 << to_tag;
    end

    // Alloc and free masks never overlap: one targets free tags, the other busy ones.
    busy_d = (busy_q & ~free_mask) | alloc_mask;

    for (int i = 0; i < 4; i++) begin
      if (alloc_mask[i]) begin
        cnt_d[i]       = 8'd0;
        cmd_store_d[i] = op_cmd;
      end else begin
        cnt_d[i]       = (busy_q[i] && (cnt_q[i] != TO_VAL)) ? cnt_q[i] + 8'd1 : cnt_q[i];
        cmd_store_d[i] = cmd_store_q[i];
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge c_clk) begin
    if (reset) begin
      req_cmd_q   <= 4'd0;
      req_data_q  <= 32'd0;
      req_tag_q   <= 2'd0;
      op_ready_q  <= 1'b0;
      busy_q      <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
      cpl_valid_q <= 1'b0;
      cpl_resp_q  <= 2'd0;
      cpl_data_q  <= 32'd0;
      cpl_tag_q   <= 2'd0;
      cpl_cmd_q   <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      op_ready_q  <= op_ready_d;
      busy_q      <= busy_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      cpl_valid_q <= cpl_valid_d;
      cpl_resp_q  <= cpl_resp_d;
      cpl_data_q  <= cpl_data_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_cmd_q   <= cpl_cmd_d;
      err_q       <= err_d;
    end
  end

  // Operand and per-tag command storage is only read for busy tags or in CMD,
  // so it needs no reset.
  always_ff @(posedge c_clk) begin
    data2_q   <= data2_d;
    cur_tag_q <= cur_tag_d;
    for (int i = 0; i < 4; i++) cmd_store_q[i] <= cmd_store_d[i];
  end

  assign op_ready       = op_ready_q;
  assign req_cmd_out    = req_cmd_q;
  assign req_data_out   = req_data_q;
  assign req_tag_out    = req_tag_q;
  assign cpl_valid      = cpl_valid_q;
  assign cpl_resp       = cpl_resp_q;
  assign cpl_data       = cpl_data_q;
  assign cpl_tag        = cpl_tag_q;
  assign cpl_cmd        = cpl_cmd_q;
  assign err_unexpected = err_q;
  assign outstanding    = {2'b00, busy_q[0]} + {2'b00, busy_q[1]}
                        + {2'b00, busy_q[2]} + {2'b00, busy_q[3]};

endmodule

// File: tb/tb_calc2_req_issuer.sv
module tb_calc2_req_issuer;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  resp_in;
  logic [31:0] resp_data_in;
  logic [1:0]  resp_tag_in;
  logic        cpl_valid;
  logic [1:0]  cpl_resp;
  logic [31:0] cpl_data;
  logic [1:0]  cpl_tag;
  logic [3:0]  cpl_cmd;
  logic [2:0]  outstanding;
  logic        err_unexpected;

  int n_vec  = 0;
  int n_miss = 0;

  calc2_req_issuer #(.TIMEOUT_CYCLES(63)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
    .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .resp_in(resp_in), .resp_data_in(resp_data_in), .resp_tag_in(resp_tag_in),
    .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data),
    .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 c_clk = ~c_clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resp(input logic [1:0] r, input logic [1:0] t, input logic [31:0] d);
    resp_in = r; resp_tag_in = t; resp_data_in = d;
  endtask

  initial begin
    logic seen_cpl;
    reset = 1'b1; op_valid = 1'b0; op_cmd = 4'd0; op_data1 = 32'd0; op_data2 = 32'd0;
    resp(2'd0, 2'd0, 32'd0);
    tick(); tick();

    // Reset state
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_cpl_valid", 32'(cpl_valid), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    chk("rst_req_cmd", 32'(req_cmd_out), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(op_ready), 32'd1);

    // Single add: CMD beat, OP2 beat, then ok response
    op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'h56; op_data2 = 32'h103;
    tick();
    op_valid = 1'b0;
    chk("add_cmd_cmd", 32'(req_cmd_out), 32'd1);
    chk("add_cmd_data", req_data_out, 32'h56);
    chk("add_cmd_tag", 32'(req_tag_out), 32'd0);
    chk("add_cmd_ready", 32'(op_ready), 32'd0);
    chk("add_outstanding", 32'(outstanding), 32'd1);
    tick();
    chk("add_op2_cmd", 32'(req_cmd_out), 32'd0);
    chk("add_op2_data", req_data_out, 32'h103);
    chk("add_op2_tag", 32'(req_tag_out), 32'd0);
    tick();
    chk("idle_data", req_data_out, 32'd0);
    resp(2'd1, 2'd0, 32'h159);
    tick();
    resp(2'd0, 2'd0, 32'd0);
    chk("add_cpl_valid", 32'(cpl_valid), 32'd1);
    chk("add_cpl_resp", 32'(cpl_resp), 32'd1);
    chk("add_cpl_data", cpl_data, 32'h159);
    chk("add_cpl_tag", 32'(cpl_tag), 32'd0);
    chk("add_cpl_cmd", 32'(cpl_cmd), 32'd1);
    chk("add_cpl_outstanding", 32'(outstanding), 32'd0);
    tick();
    chk("cpl_pulse_low", 32'(cpl_valid), 32'd0);
    chk("cpl_data_hold", cpl_data, 32'h159);

    // Back-to-back ops fill all four tags, two cycles apart
    chk("b2b_ready0", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_cmd = 4'd2;
    for (int i = 0; i < 4; i++) begin
      op_data1 = 32'(i); op_data2 = 32'h10 + 32'(i);
      tick();
      chk("b2b_tag", 32'(req_tag_out), 32'(i));
      chk("b2b_cmd", 32'(req_cmd_out), 32'd2);
      tick();
      chk("b2b_op2_data", req_data_out, 32'h10 + 32'(i));
    end
    chk("full_ready", 32'(op_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    op_cmd = 4'd5; op_data1 = 32'h55; op_data2 = 32'h66;
    tick();
    chk("full_stall_ready", 32'(op_ready), 32'd0);
    chk("full_stall_cmd", 32'(req_cmd_out), 32'd0);
    resp(2'd1, 2'd2, 32'hAA);
    tick();
    resp(2'd0, 2'd0, 32'd0);
    chk("free2_cpl_tag", 32'(cpl_tag), 32'd2);
    chk("free2_cpl_cmd", 32'(cpl_cmd), 32'd2);
    chk("free2_ready", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    chk("reuse_tag", 32'(req_tag_out), 32'd2);
    chk("reuse_cmd", 32'(req_cmd_out), 32'd5);
    chk("reuse_data", req_data_out, 32'h55);
    tick();
    for (int t = 0; t < 4; t++) begin
      resp(2'd2, 2'(t), 32'hE0 + 32'(t));
      tick();
      chk("drain_valid", 32'(cpl_valid), 32'd1);
      chk("drain_tag", 32'(cpl_tag), 32'(t));
      chk("drain_resp", 32'(cpl_resp), 32'd2);
    end
    chk("drain_cmd_tag3", 32'(cpl_cmd), 32'd2);
    resp(2'd0, 2'd0, 32'd0);
    tick();
    chk("drain_outstanding", 32'(outstanding), 32'd0);

    // Lone timeout: completion exactly 64 cycles after the allocation edge
    op_valid = 1'b1; op_cmd = 4'd6; op_data1 = 32'h1; op_data2 = 32'h2;
    tick();
    op_valid = 1'b0;
    for (int e = 1; e < 63; e++) tick();
    tick();
    chk("to_early", 32'(cpl_valid), 32'd0);
    tick();
    chk("to_valid", 32'(cpl_valid), 32'd1);
    chk("to_resp", 32'(cpl_resp), 32'd3);
    chk("to_data", cpl_data, 32'd0);
    chk("to_tag", 32'(cpl_tag), 32'd0);
    chk("to_cmd", 32'(cpl_cmd), 32'd6);
    tick();
    chk("to_pulse_low", 32'(cpl_valid), 32'd0);
    chk("to_outstanding", 32'(outstanding), 32'd0);

    // Response on tag1 in the cycle tag0 saturates: response first, timeout next
    op_valid = 1'b1; op_cmd = 4'd6;
    tick();
    op_cmd = 4'd5;
    tick();
    tick();
    op_valid = 1'b0;
    chk("pri_tag1_issue", 32'(req_tag_out), 32'd1);
    for (int e = 3; e <= 63; e++) tick();
    chk("pri_none_yet", 32'(cpl_valid), 32'd0);
    resp(2'd1, 2'd1, 32'h77);
    tick();
    resp(2'd0, 2'd0, 32'd0);
    chk("pri_resp_valid", 32'(cpl_valid), 32'd1);
    chk("pri_resp_tag", 32'(cpl_tag), 32'd1);
    chk("pri_resp_code", 32'(cpl_resp), 32'd1);
    chk("pri_resp_data", cpl_data, 32'h77);
    chk("pri_resp_cmd", 32'(cpl_cmd), 32'd5);
    tick();
    chk("pri_to_valid", 32'(cpl_valid), 32'd1);
    chk("pri_to_tag", 32'(cpl_tag), 32'd0);
    chk("pri_to_code", 32'(cpl_resp), 32'd3);
    chk("pri_to_cmd", 32'(cpl_cmd), 32'd6);
    chk("pri_outstanding", 32'(outstanding), 32'd0);

    // Unexpected response: no completion, sticky error
    resp(2'd1, 2'd3, 32'h99);
    tick();
    resp(2'd0, 2'd0, 32'd0);
    chk("unexp_no_cpl", 32'(cpl_valid), 32'd0);
    chk("unexp_err", 32'(err_unexpected), 32'd1);
    tick(); tick();
    chk("unexp_sticky", 32'(err_unexpected), 32'd1);

    // Reset during OP2 with three tags outstanding
    op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'h100; op_data2 = 32'h200;
    tick(); tick();
    op_data2 = 32'h201;
    tick(); tick();
    op_data2 = 32'h202;
    tick();
    op_valid = 1'b0;
    tick();
    chk("mid_outstanding", 32'(outstanding), 32'd3);
    chk("mid_op2_data", req_data_out, 32'h202);
    reset = 1'b1;
    resp(2'd1, 2'd0, 32'h123);
    tick();
    reset = 1'b0;
    resp(2'd0, 2'd0, 32'd0);
    chk("mr_req_cmd", 32'(req_cmd_out), 32'd0);
    chk("mr_req_data", req_data_out, 32'd0);
    chk("mr_req_tag", 32'(req_tag_out), 32'd0);
    chk("mr_ready", 32'(op_ready), 32'd0);
    chk("mr_cpl_valid", 32'(cpl_valid), 32'd0);
    chk("mr_cpl_data", cpl_data, 32'd0);
    chk("mr_cpl_resp", 32'(cpl_resp), 32'd0);
    chk("mr_err", 32'(err_unexpected), 32'd0);
    chk("mr_outstanding", 32'(outstanding), 32'd0);
    seen_cpl = 1'b0;
    for (int e = 0; e < 80; e++) begin
      tick();
      if (cpl_valid) seen_cpl = 1'b1;
    end
    chk("mr_no_late_cpl", 32'(seen_cpl), 32'd0);
    chk("mr_ready_back", 32'(op_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/calc2_req_issuer.md
CALC2_REQ_ISSUER -- requirements
Module: calc2_req_issuer

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYCLES, 63, cycles a tag may stay outstanding before a timeout completion is generated (range 3..255).
REQ-002 Ports SHALL be (name  direction  width  meaning):
  c_clk  input  1  single clock, all logic on rising edge
  reset  input  1  synchronous, active-high reset
  op_valid  input  1  upstream operation valid
  op_ready  output  1  issuer can accept an operation this cycle
  op_cmd  input  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others passed through)
  op_data1  input  32  operand 1
  op_data2  input  32  operand 2
  req_cmd_out  output  4  to calc2 reqN_cmd_in
  req_data_out  output  32  to calc2 reqN_data_in
  req_tag_out  output  2  to calc2 reqN_tag_in
  resp_in  input  2  from calc2 out_respN (0 none, 1 ok, 2 error, 3 unused)
  resp_data_in  input  32  from calc2 out_dataN
  resp_tag_in  input  2  from calc2 out_tagN
  cpl_valid  output  1  one-cycle completion pulse
  cpl_resp  output  2  1 ok, 2 calc error, 3 timeout or illegal response code
  cpl_data  output  32  result data (0 on timeout)
  cpl_tag  output  2  tag of completed operation
  cpl_cmd  output  4  command originally issued under cpl_tag
  outstanding  output  3  number of tags in flight (0..4)
  err_unexpected  output  1  sticky: response for a non-outstanding tag seen

Function
REQ-003 Issue FSM SHALL have states IDLE, CMD, OP2; all req_* outputs registered.
REQ-004 op_ready SHALL be 1 only in IDLE or OP2, with at least one free tag in the registered tag bitmap, and reset low.
REQ-005 On accept (op_valid & op_ready at edge T): lowest-numbered free tag allocated, cmd/data1/data2 latched, cmd stored per tag, tag marked busy, FSM -> CMD.
REQ-006 In CMD cycle: req_cmd_out=op_cmd, req_data_out=op_data1, req_tag_out=tag; FSM -> OP2.
REQ-007 In OP2 cycle: req_cmd_out=0, req_data_out=op_data2, req_tag_out=tag; FSM -> CMD if a new op is accepted this cycle, else IDLE.
REQ-008 In IDLE: req_cmd_out=0, req_data_out=0, req_tag_out=0; sustained throughput SHALL be one op per 2 cycles.
REQ-009 Per-tag counter SHALL clear at allocation, increment each cycle while busy, saturate at TIMEOUT_CYCLES.
REQ-010 resp_in!=0 with busy resp_tag_in: next cycle cpl_valid=1, cpl_resp=resp_in, cpl_data=resp_data_in, cpl_tag=resp_tag_in, cpl_cmd=stored cmd; tag freed.
REQ-011 resp_in!=0 with non-busy tag: no completion, err_unexpected set to 1 until reset.
REQ-012 Counter at TIMEOUT_CYCLES and no response this cycle: completion with cpl_resp=3, cpl_data=0; tag freed.
REQ-013 Response SHALL take priority over any timeout in the same cycle; pending timeouts fire in later cycles, lowest tag first, one per cycle.
REQ-014 A tag freed in cycle T SHALL be allocatable no earlier than cycle T+1.
REQ-015 cpl_valid SHALL be 0 in every cycle without a completion; cpl_* hold last values.
REQ-016 outstanding SHALL equal the popcount of the registered busy bitmap.

Reset
REQ-017 reset sampled high SHALL on that edge: FSM -> IDLE, bitmap and counters cleared, all outputs 0 (including err_unexpected, op_ready).
REQ-018 Reset mid-operation SHALL abandon any CMD/OP2 sequence and produce no completions for previously outstanding tags.
REQ-019 Responses arriving while reset is high SHALL be ignored.

Verification
REQ-020 Accept cmd 1, data1 0x56, data2 0x103 -> CMD cycle 1/0x56/tag0, OP2 cycle 0/0x103/tag0; resp 1 data 0x159 tag0 -> cpl 1/0x159/tag0/cmd1.
REQ-021 Five back-to-back ops, no responses -> tags 0,1,2,3 issued two cycles apart, outstanding=4, op_ready=0; response tag2 -> next op uses tag2.
REQ-022 Issue one op, no response -> cpl_resp=3, cpl_data=0, tag0 exactly TIMEOUT_CYCLES+1 cycles after allocation edge.
REQ-023 Response on tag1 same cycle tag0 times out -> tag1 ok completion first, tag0 timeout completion next cycle.
REQ-024 resp 1 on tag3 with nothing outstanding -> no cpl_valid, err_unexpected=1 sticky until reset.
REQ-025 Reset asserted during OP2 with 3 tags outstanding -> next cycle all outputs 0, outstanding=0, no later completions.
